// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the shared MIPS datapath.
// The master side is the controller; the slave side is the datapath.
interface mc_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        PCWr;
    logic        IRWr;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  RegDst;
    logic [1:0]  Data_to_Reg_sel;
    logic [1:0]  PC_sel;
    logic        ALUSrc;
    logic        ExtOp;
    logic [2:0]  ALUCtr;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instr_cnt;

    modport master (
        input  op, funct, zero, mem_ready,
        output PCWr, IRWr, RegWrite, MemRead, MemWrite, RegDst, Data_to_Reg_sel, PC_sel,
               ALUSrc, ExtOp, ALUCtr, state, illegal, instr_cnt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  PCWr, IRWr, RegWrite, MemRead, MemWrite, RegDst, Data_to_Reg_sel, PC_sel,
               ALUSrc, ExtOp, ALUCtr, state, illegal, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath, stalls on mem_ready, flags illegal opcodes and counts retired instructions.
module mc_ctrl (
    input logic       clk,
    input logic       reset,
    mc_ctrl_if.master bus
);
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] EXE     = 4'd2;
    localparam logic [3:0] MEM_ADR = 4'd3;
    localparam logic [3:0] MEM_RD  = 4'd4;
    localparam logic [3:0] MEM_WB  = 4'd5;
    localparam logic [3:0] MEM_WR  = 4'd6;
    localparam logic [3:0] ALU_WB  = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] JUMP    = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [3:0]  state_q, state_d;
    logic [31:0] cnt_q;
    logic        illegal_q, illegal_d;
    logic        retire;

    logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal;

    always_comb begin
        is_rtype = (bus.op == OP_RTYPE);
        is_addu  = is_rtype && (bus.funct == FN_ADDU);
        is_subu  = is_rtype && (bus.funct == FN_SUBU);
        is_jr    = is_rtype && (bus.funct == FN_JR);
        is_ori   = (bus.op == OP_ORI);
        is_lui   = (bus.op == OP_LUI);
        is_lw    = (bus.op == OP_LW);
        is_sw    = (bus.op == OP_SW);
        is_beq   = (bus.op == OP_BEQ);
        is_j     = (bus.op == OP_J);
        is_jal   = (bus.op == OP_JAL);
    end

    always_comb begin
        state_d   = FETCH;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (is_addu || is_subu || is_ori || is_lui) begin
                    state_d = EXE;
                end else if (is_lw || is_sw) begin
                    state_d = MEM_ADR;
                end else if (is_beq) begin
                    state_d = BRANCH;
                end else if (is_j || is_jal || is_jr) begin
                    state_d = JUMP;
                end else begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            EXE:     state_d = ALU_WB;
            MEM_ADR: state_d = is_lw ? MEM_RD : MEM_WR;
            MEM_RD:  state_d = bus.mem_ready ? MEM_WB : MEM_RD;
            MEM_WR: begin
                state_d = bus.mem_ready ? FETCH : MEM_WR;
                retire  = bus.mem_ready;
            end
            ALU_WB, MEM_WB, BRANCH, JUMP: retire = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            cnt_q     <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (retire) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Reset gates every strobe and select, so a pending memory access is dropped at once.
    always_comb begin
        bus.PCWr            = 1'b0;
        bus.IRWr            = 1'b0;
        bus.RegWrite        = 1'b0;
        bus.MemRead         = 1'b0;
        bus.MemWrite        = 1'b0;
        bus.RegDst          = 2'b00;
        bus.Data_to_Reg_sel = 2'b00;
        bus.PC_sel          = 2'b00;
        bus.ALUSrc          = 1'b0;
        bus.ExtOp           = 1'b0;
        bus.ALUCtr          = 3'b000;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.IRWr    = bus.mem_ready;
                    bus.PCWr    = bus.mem_ready;
                end
                EXE, ALU_WB: begin
                    bus.ALUSrc = is_ori || is_lui;
                    bus.ALUCtr = is_lui ? 3'b011 : is_ori ? 3'b010 : is_subu ? 3'b001 : 3'b000;
                    if (state_q == ALU_WB) begin
                        bus.RegWrite = 1'b1;
                        bus.RegDst   = is_rtype ? 2'b01 : 2'b00;
                    end
                end
                MEM_ADR, MEM_RD, MEM_WR: begin
                    bus.ALUSrc   = 1'b1;
                    bus.ExtOp    = 1'b1;
                    bus.MemRead  = (state_q == MEM_RD);
                    bus.MemWrite = (state_q == MEM_WR);
                end
                MEM_WB: begin
                    bus.RegWrite        = 1'b1;
                    bus.Data_to_Reg_sel = 2'b01;
                end
                BRANCH: begin
                    bus.ALUCtr = 3'b001;
                    bus.PC_sel = 2'b01;
                    bus.ExtOp  = 1'b1;
                    bus.PCWr   = bus.zero;
                end
                JUMP: begin
                    bus.PCWr   = 1'b1;
                    bus.PC_sel = is_jr ? 2'b11 : 2'b10;
                    if (is_jal) begin
                        bus.RegWrite        = 1'b1;
                        bus.RegDst          = 2'b10;
                        bus.Data_to_Reg_sel = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.illegal   = illegal_q;
    assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction is expanded into its expected per-cycle sequence of
// states and control words, then replayed against the DUT with random stalls.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  st;
        logic        mr;
        logic [15:0] ctl;
    } cyc_t;

    cyc_t        q[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        pend_ill = 1'b0;
    logic [15:0] ctl_obs;

    // Kinds: 0 addu 1 subu 2 jr 3 ori 4 lui 5 lw 6 sw 7 beq 8 j 9 jal 10 illegal
    logic [5:0] op_tab [11] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                                6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011,
                                6'b111111};

    assign ctl_obs = {bus.PCWr, bus.IRWr, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.RegDst,
                      bus.Data_to_Reg_sel, bus.PC_sel, bus.ALUSrc, bus.ExtOp, bus.ALUCtr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic pcwr, input logic irwr, input logic rw,
                                       input logic mrd, input logic mwr, input logic [1:0] rdst,
                                       input logic [1:0] d2r, input logic [1:0] pcs,
                                       input logic alus, input logic ext,
                                       input logic [2:0] alu);
        return {pcwr, irwr, rw, mrd, mwr, rdst, d2r, pcs, alus, ext, alu};
    endfunction

    function automatic void push(input logic [3:0] st, input logic mr, input logic [15:0] ctl);
        cyc_t c;
        c.st  = st;
        c.mr  = mr;
        c.ctl = ctl;
        q.push_back(c);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle sequence of one instruction, derived from its class.
    function automatic void build(input int kind, input int fst, input int mst, input logic z);
        logic [15:0] c;
        logic [2:0]  alu;
        q.delete();
        for (int i = 0; i < fst; i++) push(4'd0, 1'b0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(4'd0, 1'b1, mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(4'd1, rb(), 16'd0);
        case (kind)
            0, 1: begin
                alu = (kind == 1) ? 3'b001 : 3'b000;
                push(4'd2, rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, alu));
                push(4'd7, rb(), mk(0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, alu));
            end
            3, 4: begin
                alu = (kind == 3) ? 3'b010 : 3'b011;
                push(4'd2, rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, alu));
                push(4'd7, rb(), mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, alu));
            end
            5: begin
                push(4'd3, rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
                c = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
                for (int i = 0; i < mst; i++) push(4'd4, 1'b0, c);
                push(4'd4, 1'b1, c);
                push(4'd5, rb(), mk(0, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0));
            end
            6: begin
                push(4'd3, rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
                c = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
                for (int i = 0; i < mst; i++) push(4'd6, 1'b0, c);
                push(4'd6, 1'b1, c);
            end
            7: push(4'd8, rb(), mk(z, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1, 3'b001));
            2: push(4'd9, rb(), mk(1, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0));
            8: push(4'd9, rb(), mk(1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0));
            9: push(4'd9, rb(), mk(1, 0, 1, 0, 0, 2'b10, 2'b10, 2'b10, 0, 0, 0));
            default: ;
        endcase
    endfunction

    function automatic void pick_enc(input int kind, output logic [5:0] op, output logic [5:0] fn);
        op = op_tab[kind];
        fn = 6'($urandom);
        case (kind)
            0: fn = 6'b100001;
            1: fn = 6'b100011;
            2: fn = 6'b001000;
            10: begin
                case ($urandom_range(0, 2))
                    0: op = 6'b111111;
                    1: begin op = 6'b000000; fn = 6'b000000; end
                    default: op = 6'b001000;
                endcase
            end
            default: ;
        endcase
    endfunction

    // Entered and left on a falling edge; abort_wr asserts reset in the first MEM_WR stall.
    task automatic run_instr(input int kind, input int fst, input int mst, input logic z,
                             input logic abort_wr);
        logic [5:0] op, fn;
        pick_enc(kind, op, fn);
        build(kind, fst, mst, z);
        for (int i = 0; i < q.size(); i++) begin
            bus.op        = op;
            bus.funct     = fn;
            bus.zero      = z;
            bus.mem_ready = q[i].mr;
            if (abort_wr && q[i].st == 4'd6) begin
                reset = 1'b1;
                #1;
                check("abort_state", bus.state, 4'd6);
                check("abort_ctl", ctl_obs, 16'd0);
                @(negedge clk);
                reset    = 1'b0;
                exp_cnt  = 32'd0;
                pend_ill = 1'b0;
                return;
            end
            #1;
            check("state", bus.state, q[i].st);
            check("ctl", ctl_obs, q[i].ctl);
            check("instr_cnt", bus.instr_cnt, exp_cnt);
            check("illegal", bus.illegal, (i == 0) && pend_ill);
            @(negedge clk);
        end
        pend_ill = (kind == 10);
        if (kind != 10) exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_state", bus.state, 4'd0);
        check("rst_ctl", ctl_obs, 16'd0);
        check("rst_cnt", bus.instr_cnt, 32'd0);
        check("rst_illegal", bus.illegal, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(0, 0, 0, 1'b0, 1'b0);
        run_instr(3, 0, 0, 1'b0, 1'b0);
        run_instr(5, 0, 2, 1'b0, 1'b0);
        run_instr(6, 0, 1, 1'b0, 1'b0);
        run_instr(7, 0, 0, 1'b1, 1'b0);
        run_instr(7, 0, 0, 1'b0, 1'b0);
        run_instr(9, 0, 0, 1'b0, 1'b0);
        run_instr(2, 0, 0, 1'b0, 1'b0);
        run_instr(10, 0, 0, 1'b0, 1'b0);
        run_instr(1, 2, 0, 1'b0, 1'b0);
        run_instr(4, 1, 0, 1'b0, 1'b0);
        run_instr(8, 0, 0, 1'b0, 1'b0);
        run_instr(6, 0, 2, 1'b0, 1'b1);
        run_instr(10, 0, 0, 1'b0, 1'b0);
        run_instr(10, 1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            run_instr($urandom_range(0, 10), $urandom_range(0, 2), $urandom_range(0, 2),
                      rb(), 1'b0);
        end
        run_instr(0, 0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM that sequences the shared MIPS datapath (PC, IM/DM, GPR, EXT, ALU, NPC) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, one step per clock. It replaces the single-cycle decoder so that one ALU and one memory port serve every instruction phase. It also stalls on a memory-ready handshake, flags illegal instructions, and counts retired instructions.

## Interface
- No parameters.
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- op  input  6  IR[31:26], valid from DECODE onward
- funct  input  6  IR[5:0]
- zero  input  1  ALU equality flag (beq)
- mem_ready  input  1  memory access completes this cycle
- PCWr  output  1  PC write enable
- IRWr  output  1  instruction register write enable
- RegWrite  output  1  GPR write enable
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- RegDst  output  2  00 rt, 01 rd, 10 $31
- Data_to_Reg_sel  output  2  00 ALU, 01 DM, 10 PC
- PC_sel  output  2  00 PC+4, 01 branch, 10 j/jal, 11 jr
- ALUSrc  output  1  0 GPR B, 1 ext_out
- ExtOp  output  1  0 zero-extend, 1 sign-extend
- ALUCtr  output  3  000 add, 001 sub, 010 or, 011 lui (B<<16)
- state  output  4  current state encoding (debug)
- illegal  output  1  one-cycle pulse on unsupported instruction
- instr_cnt  output  32  retired-instruction counter

## Operation
- Supported: addu(0/100001), subu(0/100011), jr(0/001000), ori(001101), lui(001111), lw(100011), sw(101011), beq(000100), j(000010), jal(000011).
- States: FETCH=0, DECODE=1, EXE=2, MEM_ADR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, ALU_WB=7, BRANCH=8, JUMP=9; 10-15 unreachable, decode to FETCH.
- FETCH: MemRead=1; when mem_ready: IRWr=1, PCWr=1, PC_sel=00, next DECODE; else hold FETCH.
- DECODE: no strobes. R-type addu/subu, ori, lui -> EXE; lw/sw -> MEM_ADR; beq -> BRANCH; j/jal/jr -> JUMP; else -> FETCH, illegal=1.
- EXE: ALUSrc=0, ALUCtr add/sub for R-type; ALUSrc=1, ExtOp=0, ALUCtr=010 for ori, 011 for lui. Next ALU_WB.
- ALU_WB: RegWrite=1, Data_to_Reg_sel=00, RegDst=01 (R) or 00 (I); hold EXE ALU controls. Next FETCH, retire.
- MEM_ADR: ALUSrc=1, ExtOp=1, ALUCtr=000. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead=1, address controls held; mem_ready -> MEM_WB, else hold.
- MEM_WB: RegWrite=1, RegDst=00, Data_to_Reg_sel=01. Next FETCH, retire.
- MEM_WR: MemWrite=1, address controls held; mem_ready -> FETCH (retire), else hold with MemWrite still high.
- BRANCH: ALUSrc=0, ALUCtr=001, PC_sel=01, ExtOp=1, PCWr=zero. Next FETCH, retire.
- JUMP: PCWr=1; PC_sel=10 (j/jal) or 11 (jr); jal also RegWrite=1, RegDst=10, Data_to_Reg_sel=10 (PC already holds PC+4). Next FETCH, retire.
- Any output not listed for a state is 0.
- Retire: instr_cnt += 1 on the transition to FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP. Wraps 0xFFFFFFFF -> 0. Illegal instructions do not retire.

## Timing
- Reset: state=FETCH, instr_cnt=0, illegal=0. While reset=1 all write/strobe outputs (PCWr, IRWr, RegWrite, MemWrite, MemRead) forced 0; mux selects 0.
- Reset mid-instruction: next cycle FETCH, no retire, pending memory strobe dropped.
- Control outputs combinational from state/op/funct/zero/mem_ready (Moore except the mem_ready/zero-gated enables); state, instr_cnt, illegal registered.
- Latency with mem_ready=1 always: beq/j/jal/jr 3 cycles, R-type/ori/lui/sw 4, lw 5. Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle.
- illegal asserts the cycle after DECODE (aligned with FETCH), high exactly one cycle.

## Test plan
- Reset held 2 cycles then released, mem_ready=1 -> state=0, instr_cnt=0, first cycle MemRead=1, IRWr=1, PCWr=1.
- addu (funct 100001) then ori -> states 0,1,2,7 each; ALU_WB: RegWrite=1, RegDst=01 then 00, ALUCtr 000 then 010; instr_cnt=2 after 8 cycles.
- lw with mem_ready low 2 cycles in MEM_RD -> 7 cycles total, MEM_WB RegWrite=1, Data_to_Reg_sel=01; sw with 1 stall -> MemWrite high 2 cycles, no RegWrite.
- beq zero=1 then zero=0 -> PCWr=1 then 0 in BRANCH, PC_sel=01, both retire in 3 cycles.
- jal -> JUMP: PCWr=1, PC_sel=10, RegWrite=1, RegDst=10, Data_to_Reg_sel=10; jr -> PC_sel=11, RegWrite=0.
- op=111111 -> illegal pulse one cycle, instr_cnt unchanged; reset asserted in MEM_WR with mem_ready=0 -> MemWrite=0, state=FETCH next cycle.
